div_n: RTL and testbench

//  Parametrised sequential restoring divider; next generation of the 16-bit divider block.

---
 rtl/div_n_if.sv | 28 ++
 rtl/div_n.sv | 144 ++++++++++++++
 tb/tb_div_n.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_n_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_n_if : start/done handshake and operand/result bus for div_n      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface div_n_if #(
    parameter int WIDTH = 16
);
    logic             init_in;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Remainder;
    logic             done;
    logic             busy;
    logic             dbz;

    modport master (
        output init_in, A, B,
        input  Result, Remainder, done, busy, dbz
    );

    modport slave (
        input  init_in, A, B,
        output Result, Remainder, done, busy, dbz
    );
endinterface
`default_nettype wire

// File: rtl/div_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | div_n : sequential restoring divider, one quotient bit per clock      |
// |         DIV_SIGNED_EN selects two's-complement operands               |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module div_n #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic clk,
    input  wire logic rst,
    div_n_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

    // Once the partial remainder is below the divisor, the kept difference fits in WIDTH bits.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, div_q});
        rem_step = fits ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
    end

`ifdef DIV_SIGNED_EN
    logic neg_a_q, neg_a_d;
    logic neg_q_q, neg_q_d;

    always_comb begin
        a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
        // Divide-by-zero keeps the all-ones quotient; the remainder sign fix restores A.
        fin_q = (neg_q_q && (div_q != '0)) ? -quo_step : quo_step;
        fin_r = neg_a_q ? -rem_step : rem_step;
    end
`else
    always_comb begin
        a_mag = bus.A;
        b_mag = bus.B;
        fin_q = quo_step;
        fin_r = rem_step;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        res_d   = res_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_a_d = neg_a_q;
        neg_q_d = neg_q_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.init_in) begin
                    quo_d   = a_mag;
                    div_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CALC;
`ifdef DIV_SIGNED_EN
                    neg_a_d = bus.A[WIDTH-1];
                    neg_q_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`endif
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = fin_q;
                    rmd_d   = fin_r;
                    dbz_d   = (div_q == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            res_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_a_q <= 1'b0;
            neg_q_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            res_q   <= res_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_a_q <= neg_a_d;
            neg_q_q <= neg_q_d;
`endif
        end
    end

    assign bus.Result    = res_q;
    assign bus.Remainder = rmd_q;
    assign bus.dbz       = dbz_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_div_n.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_div_n : randomized self-checking bench for div_n                   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_div_n;
    localparam int WIDTH = 16;
    typedef logic [WIDTH-1:0] word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_n_if #(.WIDTH(WIDTH)) bus();
    div_n #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int    n_chk  = 0;
    int    n_pass = 0;
    word_t last_q;
    word_t last_r;
    logic  last_z;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic void model(input word_t a, input word_t b,
                                  output word_t q, output word_t r, output logic z);
`ifdef DIV_SIGNED_EN
        longint sa, sb;
`endif
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = word_t'(sa / sb);
            r  = word_t'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    task automatic run_op(input word_t a, input word_t b);
        word_t eq, er;
        logic  ez;
        int    n;
        model(a, b, eq, er, ez);
        @(negedge clk);
        bus.init_in = 1'b1;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        check("busy_at_start", bus.busy, 1);
        check("result_held_at_start", bus.Result, last_q);
        bus.A = word_t'($urandom);
        bus.B = word_t'($urandom);
        bus.init_in = 1'($urandom % 2);
        n = 0;
        while (!bus.done && n < WIDTH + 4) begin
            @(negedge clk);
            n++;
            bus.init_in = (n < WIDTH - 3) ? 1'($urandom % 2) : 1'b0;
        end
        check("latency", n, WIDTH);
        check("result", bus.Result, eq);
        check("remainder", bus.Remainder, er);
        check("dbz", bus.dbz, ez);
        check("busy_at_done", bus.busy, 1);
        last_q = eq;
        last_r = er;
        last_z = ez;
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("busy_cleared", bus.busy, 0);
        check("remainder_held", bus.Remainder, last_r);
    endtask

    initial begin
        word_t a, b;
        int    pulses;
        rst = 1'b0;
        bus.init_in = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.Result, 0);
        check("rst_remainder", bus.Remainder, 0);
        check("rst_dbz", bus.dbz, 0);
        rst = 1'b1;
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;

        run_op(16'h95EC, 16'h00CA);
        run_op(16'd100, 16'd7);
        run_op(16'h1234, 16'h0000);
        run_op(16'd9, 16'd3);
        run_op(16'hFFF9, 16'h0002);
        run_op(16'h8000, 16'hFFFF);
        run_op(16'h0007, 16'hFFFE);
        run_op(16'h00FF, 16'h0010);
        run_op(16'h0005, 16'h0009);
        run_op(16'h0000, 16'h0005);
        run_op(16'hFFFF, 16'h0001);
        run_op(16'hFFFF, 16'hFFFF);
        run_op(16'h8000, 16'h0000);

        // Reset during the fifth CALC cycle abandons the operation.
        @(negedge clk);
        bus.init_in = 1'b1;
        bus.A = 16'h4321;
        bus.B = 16'h0011;
        @(negedge clk);
        bus.init_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_result", bus.Result, 0);
        check("midrst_remainder", bus.Remainder, 0);
        rst = 1'b1;
        pulses = 0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;

        for (int i = 0; i < 25; i++) begin
            a = word_t'($urandom);
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = word_t'($urandom_range(1, 15));
                2:       b = a;
                default: b = word_t'($urandom);
            endcase
            run_op(a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
